line_clear: RTL and testbench

- Sequential row-clear engine that sits directly upstream of the display/overlay path.
- Takes the 10x20 static playfield after a piece locks, removes every full row and compacts the remaining rows downward.
- Produces the cleaned 200-bit static board consumed by the piece overlay and display stages, plus per-pass and running line counts for scoring.
- Board bit order: bit (r*W + c), with row 0 as the bottom row and column 0 as the leftmost column.

---
 rtl/line_clear.sv | 104 ++++++++++
 tb/tb_line_clear.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_clear.sv
// Row-clear engine: removes full rows from the locked playfield, one row per cycle,
// compacting the rows above downward, and keeps per-pass and running line counts.
module line_clear #(
    parameter int W       = 10,
    parameter int H       = 20,
    parameter int TOTAL_W = 16
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               start,
    input  logic [0:W*H-1]     board_in,
    input  logic               clr_total,
    output logic [0:W*H-1]     board_out,
    output logic               busy,
    output logic               done,
    output logic [4:0]         lines,
    output logic [TOTAL_W-1:0] lines_total
);

    localparam int RW = $clog2(H);
    localparam int SW = ((TOTAL_W > 5) ? TOTAL_W : 5) + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state;
    logic [0:W*H-1]     work;
    logic [0:W*H-1]     shifted;
    logic [RW-1:0]      row;
    logic [4:0]         cnt;
    logic               row_full;
    logic [SW-1:0]      sum;
    logic [TOTAL_W-1:0] total_sat;

    always_comb begin
        row_full = 1'b0;
        for (int r = 0; r < H; r++) begin
            if (row == RW'(r)) row_full = &work[r*W +: W];
        end
    end

    // Rows at or above the cleared row drop by one; the top row refills empty.
    always_comb begin
        shifted = work;
        for (int r = 0; r < H - 1; r++) begin
            if (RW'(r) >= row) shifted[r*W +: W] = work[(r+1)*W +: W];
        end
        shifted[(H-1)*W +: W] = '0;
    end

    always_comb begin
        sum       = SW'(lines_total) + SW'(cnt);
        total_sat = (sum > SW'({TOTAL_W{1'b1}})) ? '1 : sum[TOTAL_W-1:0];
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            work        <= '0;
            row         <= '0;
            cnt         <= '0;
            board_out   <= '0;
            lines       <= '0;
            lines_total <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (clr_total) lines_total <= '0;
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work  <= board_in;
                        row   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        work <= shifted;
                        cnt  <= cnt + 5'd1;
                    end else if (row != RW'(H - 1)) begin
                        row <= row + RW'(1);
                    end else begin
                        // Final row settled: publish in the same edge that enters DONE.
                        board_out <= work;
                        lines     <= cnt;
                        done      <= 1'b1;
                        if (!clr_total) lines_total <= total_sat;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear.sv
// Directed bench for line_clear: latency, compaction, counters, reset abort
// and saturation of the running total.
module tb_line_clear;

    logic         clk = 1'b0;
    logic         clrn;
    logic         start;
    logic         clr_total;
    logic [0:199] board_in;
    logic [0:199] board_out;
    logic         busy;
    logic         done;
    logic [4:0]   lines;
    logic [15:0]  lines_total;

    logic         start_s;
    logic         clr_total_s;
    logic [0:199] board_in_s;
    logic [0:199] board_out_s;
    logic         busy_s;
    logic         done_s;
    logic [4:0]   lines_s;
    logic [2:0]   lines_total_s;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    line_clear dut (
        .clk(clk), .clrn(clrn), .start(start), .board_in(board_in),
        .clr_total(clr_total), .board_out(board_out), .busy(busy),
        .done(done), .lines(lines), .lines_total(lines_total)
    );

    line_clear #(.TOTAL_W(3)) dut_s (
        .clk(clk), .clrn(clrn), .start(start_s), .board_in(board_in_s),
        .clr_total(clr_total_s), .board_out(board_out_s), .busy(busy_s),
        .done(done_s), .lines(lines_s), .lines_total(lines_total_s)
    );

    task automatic do_start(input logic [0:199] b);
        @(negedge clk);
        board_in = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_start_s(input logic [0:199] b);
        @(negedge clk);
        board_in_s = b;
        start_s    = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
    endtask

    task automatic wait_done_s(output int n);
        n = 1;
        while (done_s !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        clrn = 1'b1; start = 1'b0; clr_total = 1'b0; board_in = '0;
        start_s = 1'b0; clr_total_s = 1'b0; board_in_s = '0;
        #2 clrn = 1'b0;
        #10;
        checks++; if (board_out !== '0) $display("FAIL reset_board got %h want 0", board_out); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        checks++; if (lines !== 5'd0) $display("FAIL reset_lines got %0d want 0", lines); else passed++;
        checks++; if (lines_total !== 16'd0) $display("FAIL reset_total got %0d want 0", lines_total); else passed++;
        @(negedge clk);
        clrn = 1'b1;
    endtask

    task automatic test_empty;
        int n;
        do_start('0);
        checks++; if (busy !== 1'b1) $display("FAIL empty_busy got %b want 1", busy); else passed++;
        wait_done(n);
        checks++; if (n != 21) $display("FAIL empty_latency got %0d want 21", n); else passed++;
        checks++; if (lines !== 5'd0) $display("FAIL empty_lines got %0d want 0", lines); else passed++;
        checks++; if (board_out !== '0) $display("FAIL empty_board got %h want 0", board_out); else passed++;
        checks++; if (lines_total !== 16'd0) $display("FAIL empty_total got %0d want 0", lines_total); else passed++;
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL empty_idle got done=%b busy=%b want 0 0", done, busy); else passed++;
    endtask

    task automatic test_bottom_rows;
        int n;
        logic [0:199] b;
        logic [0:199] e;
        b = '0; e = '0;
        for (int i = 0; i < 40; i++) b[i] = 1'b1;
        b[40] = 1'b1; b[42] = 1'b1;
        e[0] = 1'b1; e[2] = 1'b1;
        do_start(b);
        wait_done(n);
        checks++; if (n != 25) $display("FAIL bottom_latency got %0d want 25", n); else passed++;
        checks++; if (lines !== 5'd4) $display("FAIL bottom_lines got %0d want 4", lines); else passed++;
        checks++; if (board_out !== e) $display("FAIL bottom_board got %h want %h", board_out, e); else passed++;
        checks++; if (lines_total !== 16'd4) $display("FAIL bottom_total got %0d want 4", lines_total); else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_gap_rows;
        int n;
        logic [0:199] b;
        logic [0:199] e;
        b = '0; e = '0;
        for (int c = 0; c < 10; c++) begin
            b[20 + c] = 1'b1;
            b[50 + c] = 1'b1;
        end
        b[39] = 1'b1; b[60] = 1'b1;
        e[29] = 1'b1; e[40] = 1'b1;
        do_start(b);
        wait_done(n);
        checks++; if (n != 23) $display("FAIL gap_latency got %0d want 23", n); else passed++;
        checks++; if (lines !== 5'd2) $display("FAIL gap_lines got %0d want 2", lines); else passed++;
        checks++; if (board_out !== e) $display("FAIL gap_board got %h want %h", board_out, e); else passed++;
        checks++; if (lines_total !== 16'd6) $display("FAIL gap_total got %0d want 6", lines_total); else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_top_row;
        int n;
        logic [0:199] b;
        b = '0;
        for (int c = 0; c < 10; c++) b[190 + c] = 1'b1;
        do_start(b);
        wait_done(n);
        checks++; if (n != 22) $display("FAIL top_latency got %0d want 22", n); else passed++;
        checks++; if (lines !== 5'd1) $display("FAIL top_lines got %0d want 1", lines); else passed++;
        checks++; if (board_out !== '0) $display("FAIL top_board got %h want 0", board_out); else passed++;
        checks++; if (lines_total !== 16'd7) $display("FAIL top_total got %0d want 7", lines_total); else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_full;
        int n;
        logic [0:199] b;
        b = '1;
        do_start(b);
        wait_done(n);
        checks++; if (n != 41) $display("FAIL full_latency got %0d want 41", n); else passed++;
        checks++; if (lines !== 5'd20) $display("FAIL full_lines got %0d want 20", lines); else passed++;
        checks++; if (board_out !== '0) $display("FAIL full_board got %h want 0", board_out); else passed++;
        checks++; if (lines_total !== 16'd27) $display("FAIL full_total got %0d want 27", lines_total); else passed++;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL full_idle_busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_back_to_back;
        int n;
        int dcount;
        int dcyc;
        logic busy_mid;
        logic [0:199] b;
        logic [0:199] e;
        b = '0; e = '0;
        for (int c = 0; c < 10; c++) b[c] = 1'b1;
        b[15] = 1'b1;
        e[5] = 1'b1;
        dcount = 0; dcyc = 0; busy_mid = 1'b0;
        do_start(b);
        n = 1;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) begin
                dcount++;
                dcyc = n;
            end
            if (n == 10) busy_mid = busy;
            start     = (n == 3);
            board_in  = (n == 3) ? '1 : board_in;
            clr_total = (n == 21 || n == 22);
        end
        start = 1'b0; clr_total = 1'b0;
        checks++; if (busy_mid !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy_mid); else passed++;
        checks++; if (dcount != 1) $display("FAIL b2b_done_count got %0d want 1", dcount); else passed++;
        checks++; if (dcyc != 22) $display("FAIL b2b_latency got %0d want 22", dcyc); else passed++;
        checks++; if (lines !== 5'd1) $display("FAIL b2b_lines got %0d want 1", lines); else passed++;
        checks++; if (board_out !== e) $display("FAIL b2b_board got %h want %h", board_out, e); else passed++;
        checks++; if (lines_total !== 16'd0) $display("FAIL b2b_clr_total got %0d want 0", lines_total); else passed++;
    endtask

    task automatic test_reset_midscan;
        int seen;
        logic [0:199] b;
        b = '0;
        for (int c = 0; c < 10; c++) b[c] = 1'b1;
        do_start(b);
        repeat (4) @(posedge clk);
        #3 clrn = 1'b0;
        #1;
        checks++; if (board_out !== '0) $display("FAIL abort_board got %h want 0", board_out); else passed++;
        checks++; if (lines !== 5'd0) $display("FAIL abort_lines got %0d want 0", lines); else passed++;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_flags got busy=%b done=%b want 0 0", busy, done); else passed++;
        @(negedge clk);
        clrn = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) seen++;
        end
        checks++; if (seen != 0) $display("FAIL abort_no_done got %0d want 0", seen); else passed++;
    endtask

    task automatic test_saturate;
        int n;
        logic [0:199] b4;
        logic [0:199] b2;
        b4 = '0; b2 = '0;
        for (int i = 0; i < 40; i++) b4[i] = 1'b1;
        for (int i = 0; i < 20; i++) b2[i] = 1'b1;
        do_start_s(b4);
        wait_done_s(n);
        checks++; if (lines_total_s !== 3'd4) $display("FAIL sat_first got %0d want 4", lines_total_s); else passed++;
        @(posedge clk);
        #1;
        do_start_s(b2);
        wait_done_s(n);
        checks++; if (lines_total_s !== 3'd6) $display("FAIL sat_preload got %0d want 6", lines_total_s); else passed++;
        @(posedge clk);
        #1;
        do_start_s(b4);
        wait_done_s(n);
        checks++; if (lines_total_s !== 3'd7) $display("FAIL sat_clamp got %0d want 7", lines_total_s); else passed++;
        checks++; if (lines_s !== 5'd4) $display("FAIL sat_lines got %0d want 4", lines_s); else passed++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset;
        test_empty;
        test_bottom_rows;
        test_gap_rows;
        test_top_row;
        test_all_full;
        test_back_to_back;
        test_reset_midscan;
        test_saturate;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
